fp_divsqrt_iter: RTL

Parametrised iterative floating-point divide / square-root unit with valid/ready handshaking. It computes one quotient or root bit per cycle for any IEEE-754-style format given by `EXP_W`/`FRAC_W`. Special operands resolve in a short bypass path. The unit emits an unrounded extended result (hidden bit, fraction, guard, round, sticky, wide signed exponent), which the existing normalise/round stages consume.

---
 rtl/fp_divsqrt_iter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fp_divsqrt_iter.sv
// fp_divsqrt_iter: iterative radix-2 restoring divide / square root for a parametrised IEEE-754-style format.
// Emits an unrounded {hidden, frac, G, R, S} mantissa with a wide signed exponent; special operands bypass the iteration.
module fp_divsqrt_iter #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int BIAS   = 2 ** (EXP_W - 1) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  abort,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  op,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_sign,
    output logic [EXP_W+1:0]      res_exp,
    output logic [FRAC_W+3:0]     res_mant,
    output logic                  res_special,
    output logic                  res_nv,
    output logic                  res_dz
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int M  = FRAC_W + 1;
    localparam int N  = FRAC_W + 4;
    localparam int RW = N + 3;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N);
    localparam logic [EW-1:0] BE = EW'(BIAS);
    localparam logic [FRAC_W-1:0] QBIT = {1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, DONE} state_t;
    state_t state, nxt;

    logic op_r, sp_q;
    logic [W-1:0] a_r, b_r;
    logic [CW-1:0] cnt;
    logic [N-1:0] q;
    logic [RW-1:0] rem;
    logic [2*N-1:0] rad;

    logic sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [EXP_W-1:0] ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic [M-1:0] ma, mb;
    logic [M:0] x;
    logic [EW-1:0] ue, div_exp, sqrt_exp;
    logic is_sp, sp_sign, sp_nv, sp_dz;
    logic [EXP_W-1:0] sp_exp;
    logic [FRAC_W-1:0] sp_frac;
    logic [RW-1:0] cur, trial, diff, rem_nx;
    logic qb, shl, rem_nz;

    assign {sa, ea, fa} = a_r;
    assign {sb, eb, fb} = b_r;
    assign ma = {1'b1, fa};
    assign mb = {1'b1, fb};
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;
    assign a_inf = &ea && fa == '0;
    assign b_inf = &eb && fb == '0;
    assign a_nan = &ea && fa != '0;
    assign b_nan = &eb && fb != '0;
    assign a_snan = a_nan && !fa[FRAC_W-1];
    assign b_snan = b_nan && !fb[FRAC_W-1];

    assign ue = {2'b0, ea} - BE;
    assign div_exp = {2'b0, ea} - {2'b0, eb} + BE;
    assign sqrt_exp = {ue[EW-1], ue[EW-1:1]} + BE;
    // odd unbiased exponent: fold one factor of two into the radicand
    assign x = ue[0] ? {ma, 1'b0} : {1'b0, ma};

    always_comb begin
        is_sp = 1'b1;
        sp_sign = sa ^ (sb & !op_r);
        sp_exp = '1;
        sp_frac = '0;
        sp_nv = 1'b0;
        sp_dz = 1'b0;
        if (a_nan || (!op_r && b_nan)) begin
            sp_sign = a_nan ? sa : sb;
            sp_frac = (a_nan ? fa : fb) | QBIT;
            sp_nv = a_snan || (!op_r && b_snan);
        end else if (op_r ? (sa && !a_zero) : ((a_zero && b_zero) || (a_inf && b_inf))) begin
            sp_sign = 1'b0;
            sp_frac = QBIT;
            sp_nv = 1'b1;
        end else if (!op_r && b_zero && !a_inf) begin
            sp_dz = 1'b1;
        end else if (op_r ? a_zero : (a_zero || b_inf)) begin
            sp_exp = '0;
        end else if (!a_inf) begin
            is_sp = 1'b0;
        end
    end

    // sqrt brings down two radicand bits per step and trials 4*root+1; div trials the divisor
    assign cur = op_r ? {rem[RW-3:0], rad[2*N-1 -: 2]} : rem;
    assign trial = op_r ? {1'b0, q, 2'b01} : {{(RW-M){1'b0}}, mb};
    assign qb = cur >= trial;
    assign diff = qb ? cur - trial : cur;
    assign rem_nx = op_r ? diff : {diff[RW-2:0], 1'b0};
    assign shl = !op_r && !q[N-1];
    assign rem_nz = |rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (ce) state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = req_valid ? PREP : IDLE;
            PREP: nxt = is_sp ? NORM : ITER;
            ITER: nxt = cnt == CW'(N - 1) ? NORM : ITER;
            NORM: nxt = DONE;
            DONE: nxt = res_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    always_comb begin
        req_ready = state == IDLE;
        res_valid = state == DONE;
    end

    // specials settle in PREP and pass through NORM untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
            sp_q <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            cnt <= '0;
            q <= '0;
            rem <= '0;
            rad <= '0;
            res_sign <= 1'b0;
            res_exp <= '0;
            res_mant <= '0;
            res_special <= 1'b0;
            res_nv <= 1'b0;
            res_dz <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: if (req_valid) begin
                    op_r <= op;
                    a_r <= a;
                    b_r <= b;
                end
                PREP: begin
                    sp_q <= is_sp;
                    res_special <= is_sp;
                    res_nv <= sp_nv;
                    res_dz <= sp_dz;
                    res_sign <= sp_sign;
                    res_exp <= is_sp ? {2'b0, sp_exp} : op_r ? sqrt_exp : div_exp;
                    res_mant <= {1'b0, sp_frac, 3'b000};
                    cnt <= '0;
                    q <= '0;
                    rem <= op_r ? '0 : {{(RW-M){1'b0}}, ma};
                    rad <= {x, {(FRAC_W+6){1'b0}}};
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    q <= {q[N-2:0], qb};
                    rem <= rem_nx;
                    rad <= rad << 2;
                end
                NORM: if (!sp_q) begin
                    res_mant <= shl ? {q[N-2:0], rem_nz} : {q[N-1:1], q[0] | rem_nz};
                    res_exp <= res_exp - {{(EW-1){1'b0}}, shl};
                end
                default: ;
            endcase
        end
    end
endmodule
